// File: rtl/counter_bank_pkg.sv
// Shared register-map constants and channel configuration layout for the counter bank.
package counter_bank_pkg;

  localparam logic [1:0] OFS_COUNTER = 2'd0;
  localparam logic [1:0] OFS_CONFIG  = 2'd1;
  localparam logic [1:0] OFS_LIMIT   = 2'd2;
  localparam logic [1:0] OFS_STATUS  = 2'd3;

  localparam int unsigned CFG_EN   = 0;
  localparam int unsigned CFG_DIR  = 1;
  localparam int unsigned CFG_IRE  = 2;
  localparam int unsigned CFG_MODE = 3;

  typedef struct packed {
    logic mode;
    logic ire;
    logic dir;
    logic en;
  } channel_config_t;

endpackage

// File: rtl/counter_channel.sv
// One up/down counter with limit/reload register, wrap mode and sticky event flag.
module counter_channel
  import counter_bank_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             counter_we_i,
  input  logic             cfg_we_i,
  input  logic             limit_we_i,
  input  logic             pending_clr_i,
  input  logic [31:0]      wdata_i,
  output logic [WIDTH-1:0] counter_o,
  output channel_config_t  cfg_o,
  output logic [WIDTH-1:0] limit_o,
  output logic             pending_o
);

  logic [WIDTH-1:0] counter_q, counter_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  channel_config_t  cfg_q, cfg_d;
  logic             pending_q, pending_d;
  logic             event_hit;

  always_comb begin
    counter_d = counter_q;
    event_hit = 1'b0;
    if (cfg_q.en) begin
      if (cfg_q.dir) begin
        counter_d = counter_q + WIDTH'(1);
        if (counter_q == limit_q) begin
          event_hit = 1'b1;
          if (cfg_q.mode) counter_d = '0;
        end
      end else begin
        counter_d = counter_q - WIDTH'(1);
        if (counter_q == '0) begin
          event_hit = 1'b1;
          counter_d = cfg_q.mode ? limit_q : '1;
        end
      end
    end
    // A bus write to the counter overrides the count step and suppresses its event.
    if (counter_we_i) begin
      counter_d = wdata_i[WIDTH-1:0];
      event_hit = 1'b0;
    end
    // Set beats clear when an event and a W1C land together.
    pending_d = event_hit | (pending_q & ~pending_clr_i);
    cfg_d     = cfg_we_i ? channel_config_t'(wdata_i[3:0]) : cfg_q;
    limit_d   = limit_we_i ? wdata_i[WIDTH-1:0] : limit_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      counter_q <= '0;
      limit_q   <= '1;
      cfg_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      counter_q <= counter_d;
      limit_q   <= limit_d;
      cfg_q     <= cfg_d;
      pending_q <= pending_d;
    end
  end

  assign counter_o = counter_q;
  assign cfg_o     = cfg_q;
  assign limit_o   = limit_q;
  assign pending_o = pending_q;

endmodule

// File: rtl/avalon_counter_bank.sv
// Avalon-MM slave with CHANNELS independent counters: address decode, read mux, combined irq.
module avalon_counter_bank
  import counter_bank_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned WIDTH    = 32,
  localparam int unsigned ADDR_WIDTH = $clog2(CHANNELS) + 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  read,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [31:0]           dataIn,
  output logic                  readValid,
  output logic [31:0]           dataOut,
  output logic                  irq
);

  localparam int unsigned ChBits = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [ChBits-1:0] ch_sel;
  logic [1:0]        offset;

  logic [WIDTH-1:0] counter_a [CHANNELS];
  logic [WIDTH-1:0] limit_a   [CHANNELS];
  channel_config_t  cfg_a     [CHANNELS];
  logic [CHANNELS-1:0] pending_v, ire_v;

  logic [31:0] rdata;
  logic        rvalid_q;
  logic [31:0] rdata_q;
  logic        irq_q;

  assign offset = address[1:0];

  if (CHANNELS > 1) begin : g_sel
    assign ch_sel = address[ADDR_WIDTH-1:2];
  end else begin : g_sel_single
    assign ch_sel = 1'b0;
  end

  // Channel indices at or above CHANNELS match no instance, so writes there fall away.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic sel;
    assign sel = write && (ch_sel == ChBits'(c));

    counter_channel #(
      .WIDTH(WIDTH)
    ) u_channel (
      .clk          (clk),
      .reset        (reset),
      .counter_we_i (sel && (offset == OFS_COUNTER)),
      .cfg_we_i     (sel && (offset == OFS_CONFIG)),
      .limit_we_i   (sel && (offset == OFS_LIMIT)),
      .pending_clr_i(sel && (offset == OFS_STATUS) && dataIn[0]),
      .wdata_i      (dataIn),
      .counter_o    (counter_a[c]),
      .cfg_o        (cfg_a[c]),
      .limit_o      (limit_a[c]),
      .pending_o    (pending_v[c])
    );

    assign ire_v[c] = cfg_a[c][CFG_IRE];
  end

  always_comb begin
    rdata = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (ch_sel == ChBits'(c)) begin
        unique case (offset)
          OFS_COUNTER: rdata = 32'(counter_a[c]);
          OFS_CONFIG:  rdata = 32'(cfg_a[c]);
          OFS_LIMIT:   rdata = 32'(limit_a[c]);
          OFS_STATUS:  rdata = {30'd0, (counter_a[c] < limit_a[c]), pending_v[c]};
          default:     rdata = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      rvalid_q <= read;
      rdata_q  <= read ? rdata : '0;
      irq_q    <= |(pending_v & ire_v);
    end
  end

  assign readValid = rvalid_q;
  assign dataOut   = rdata_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_avalon_counter_bank.sv
// Directed bench for avalon_counter_bank: a 4x32 instance and a 3x16 instance share one bus.
module tb_avalon_counter_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic        read;
  logic        write;
  logic [3:0]  address;
  logic [31:0] dataIn;

  logic        rv_a, irq_a, rv_b, irq_b;
  logic [31:0] do_a, do_b;

  logic        use_b;
  logic [31:0] exp_q[$];
  int          n_cmp;
  int          n_bad;

  always #5 clk = ~clk;

  avalon_counter_bank #(
    .CHANNELS(4),
    .WIDTH   (32)
  ) dut_a (
    .clk      (clk),
    .reset    (reset),
    .read     (read),
    .write    (write),
    .address  (address),
    .dataIn   (dataIn),
    .readValid(rv_a),
    .dataOut  (do_a),
    .irq      (irq_a)
  );

  avalon_counter_bank #(
    .CHANNELS(3),
    .WIDTH   (16)
  ) dut_b (
    .clk      (clk),
    .reset    (reset),
    .read     (read),
    .write    (write),
    .address  (address),
    .dataIn   (dataIn),
    .readValid(rv_b),
    .dataOut  (do_b),
    .irq      (irq_b)
  );

  function automatic logic cur_rv();
    return use_b ? rv_b : rv_a;
  endfunction

  function automatic logic [31:0] cur_do();
    return use_b ? do_b : do_a;
  endfunction

  function automatic logic cur_irq();
    return use_b ? irq_b : irq_a;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_read(input string tag);
    logic [31:0] exp;
    check({tag, "/valid"}, 32'(cur_rv()), 32'd1);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL %s: observed read data with empty scoreboard, expected none", tag);
    end else begin
      exp = exp_q.pop_front();
      check(tag, cur_do(), exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    write   = 1'b1;
    address = a;
    dataIn  = d;
    @(negedge clk);
    write   = 1'b0;
  endtask

  // n back-to-back reads of one address; expectations must already be queued.
  task automatic rd(input logic [3:0] a, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i > 0) check_read(tag);
      read    = 1'b1;
      address = a;
    end
    @(negedge clk);
    check_read(tag);
    read = 1'b0;
  endtask

  task automatic rd1(input logic [3:0] a, input logic [31:0] exp, input string tag);
    exp_q.push_back(exp);
    rd(a, 1, tag);
  endtask

  task automatic rw_same(input logic [3:0] a, input logic [31:0] d, input logic [31:0] old,
                         input string tag);
    @(negedge clk);
    read    = 1'b1;
    write   = 1'b1;
    address = a;
    dataIn  = d;
    exp_q.push_back(old);
    @(negedge clk);
    read  = 1'b0;
    write = 1'b0;
    check_read(tag);
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    use_b   = 1'b0;
    reset   = 1'b1;
    read    = 1'b0;
    write   = 1'b0;
    address = '0;
    dataIn  = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state.
    check("rst_rvalid", 32'(rv_a), 32'd0);
    check("rst_dout", do_a, 32'd0);
    check("rst_irq", 32'(irq_a), 32'd0);
    rd1(4'd0, 32'h0, "rst_ch0_counter");
    @(negedge clk);
    check("idle_rvalid", 32'(rv_a), 32'd0);
    check("idle_dout", do_a, 32'd0);
    rd1(4'd1, 32'h0, "rst_ch0_config");
    rd1(4'd2, 32'hFFFF_FFFF, "rst_ch0_limit");
    rd1(4'd3, 32'h2, "rst_ch0_status");

    // Ch1: up, reload at limit 5, irq enabled.
    wr(4'd6, 32'd5);
    wr(4'd5, 32'hF);
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd2);
    exp_q.push_back(32'd3);
    exp_q.push_back(32'd4);
    exp_q.push_back(32'd5);
    rd(4'd4, 5, "ch1_count");
    check("ch1_irq_before", 32'(irq_a), 32'd0);
    @(negedge clk);
    check("ch1_irq_rise", 32'(irq_a), 32'd1);
    wr(4'd7, 32'h1);
    check("ch1_irq_hold", 32'(irq_a), 32'd1);
    @(negedge clk);
    check("ch1_irq_clear", 32'(irq_a), 32'd0);
    // This disable lands on the 5->0 wrap, so the event still fires with irq masked.
    wr(4'd5, 32'h0);
    rd1(4'd4, 32'h0, "ch1_counter_frozen");
    rd1(4'd7, 32'h3, "ch1_status");
    check("ch1_irq_masked", 32'(irq_a), 32'd0);

    // Ch2: down, free-run from 3, irq disabled.
    wr(4'd8, 32'd3);
    wr(4'd10, 32'd10);
    wr(4'd9, 32'h1);
    exp_q.push_back(32'd2);
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'hFFFF_FFFF);
    rd(4'd8, 4, "ch2_count");
    check("ch2_irq_off", 32'(irq_a), 32'd0);
    wr(4'd9, 32'h5);
    check("ch2_irq_lag", 32'(irq_a), 32'd0);
    @(negedge clk);
    check("ch2_irq_on", 32'(irq_a), 32'd1);
    wr(4'd9, 32'h0);
    check("ch2_irq_lag2", 32'(irq_a), 32'd1);
    @(negedge clk);
    check("ch2_irq_drop", 32'(irq_a), 32'd0);
    rd1(4'd11, 32'h1, "ch2_pending_kept");

    // Ch0: event and W1C on the same edge.
    wr(4'd2, 32'd2);
    wr(4'd1, 32'hB);
    @(negedge clk);
    wr(4'd3, 32'h1);
    wr(4'd1, 32'h0);
    rd1(4'd3, 32'h1, "ch0_set_wins");
    check("ch0_irq_none", 32'(irq_a), 32'd0);

    // Ch0: counter write on the step that would have hit the limit.
    wr(4'd3, 32'h1);
    wr(4'd0, 32'h1);
    wr(4'd1, 32'hB);
    wr(4'd0, 32'h40);
    wr(4'd1, 32'h0);
    rd1(4'd0, 32'h42, "ch0_write_wins");
    rd1(4'd3, 32'h0, "ch0_no_event");

    // Simultaneous read and write returns the old value.
    rw_same(4'd14, 32'h77, 32'hFFFF_FFFF, "ch3_rw_old");
    rd1(4'd14, 32'h77, "ch3_rw_new");

    // Reset mid-count with pending set and a read in flight.
    wr(4'd14, 32'd1);
    wr(4'd13, 32'hF);
    repeat (4) @(negedge clk);
    check("ch3_irq_pre_rst", 32'(irq_a), 32'd1);
    @(negedge clk);
    reset   = 1'b1;
    read    = 1'b1;
    address = 4'd12;
    @(negedge clk);
    reset = 1'b0;
    read  = 1'b0;
    check("mid_rst_rvalid", 32'(rv_a), 32'd0);
    check("mid_rst_dout", do_a, 32'd0);
    check("mid_rst_irq", 32'(irq_a), 32'd0);
    rd1(4'd15, 32'h2, "mid_rst_ch3_status");
    rd1(4'd13, 32'h0, "mid_rst_ch3_config");
    rd1(4'd14, 32'hFFFF_FFFF, "mid_rst_ch3_limit");
    rd1(4'd7, 32'h2, "mid_rst_ch1_status");

    // Narrow build: 3 channels x 16 bits.
    use_b = 1'b1;
    rd1(4'd12, 32'h0, "b_ch3_read");
    wr(4'd12, 32'h55);
    wr(4'd14, 32'h1234);
    rd1(4'd12, 32'h0, "b_ch3_counter_ignored");
    rd1(4'd14, 32'h0, "b_ch3_limit_ignored");
    wr(4'd2, 32'h1234);
    wr(4'd0, 32'hABCD_FFFF);
    wr(4'd1, 32'h7);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h1);
    exp_q.push_back(32'h2);
    rd(4'd0, 3, "b_ch0_wrap");
    rd1(4'd3, 32'h2, "b_ch0_status");
    check("b_irq", 32'(cur_irq()), 32'd0);
    rd1(4'd1, 32'h7, "b_ch0_config");
    rd1(4'd2, 32'h1234, "b_ch0_limit");

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
